// File: rtl/multi_cycle_controller.sv
// ---------------------------------------------------------------------------
// multi_cycle_controller
//
// Control unit for a multi-cycle processor. It sequences each instruction
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath
// enables and selects from the current state and the opcode. It also keeps
// a 16-bit count of retired instructions.
//
// Parameters
//   OPW         opcode width (instruction bits [17:14])
//
// Ports
//   Clock       sole clock, rising edge
//   Clear       synchronous active-high reset
//   Opcode      opcode field of the instruction register
//   Zero        comparator equal flag (A == B)
//   Negative    comparator less-than flag (A < B, signed)
//   MemReady    memory completion handshake (looked at in FETCH and MEM only)
//   PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcB, MemToReg
//               datapath enables and selects
//   ALUControl  00 ADD, 01 AND, 10 NAND, 11 NOR
//   PCSource    00 PC+1, 01 branch target, 10 jump target
//   IllegalOp   one-cycle pulse in DECODE for an undefined opcode
//   Halted      high while parked in HALT
//   State       current FSM state code
//   Retired     count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module multi_cycle_controller #(
  parameter int OPW = 4
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic [OPW-1:0] Opcode,
  input  logic           Zero,
  input  logic           Negative,
  input  logic           MemReady,
  output logic           PCWrite,
  output logic           IRWrite,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           RegWrite,
  output logic           ALUSrcB,
  output logic           MemToReg,
  output logic [1:0]     ALUControl,
  output logic [1:0]     PCSource,
  output logic           IllegalOp,
  output logic           Halted,
  output logic [2:0]     State,
  output logic [15:0]    Retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [OPW-1:0] OP_AND  = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_NAND = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_NOR  = OPW'(4'b0011);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(4'b0100);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(4'b0101);
  localparam logic [OPW-1:0] OP_LD   = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_ST   = OPW'(4'b0111);
  localparam logic [OPW-1:0] OP_JUMP = OPW'(4'b1000);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'b1001);
  localparam logic [OPW-1:0] OP_BLT  = OPW'(4'b1010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(4'b1111);

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;
  localparam logic [1:0] ALU_NOR  = 2'b11;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  state_t state;
  state_t next_state;
  logic   retire;

  // Opcode classification
  logic       is_reg, is_imm, is_ld, is_st, is_jump, is_beq, is_blt, is_halt;
  logic       is_legal;
  logic [1:0] alu_op;

  always_comb begin
    is_reg  = (Opcode == OP_AND) || (Opcode == OP_ADD) ||
              (Opcode == OP_NAND) || (Opcode == OP_NOR);
    is_imm  = (Opcode == OP_ANDI) || (Opcode == OP_ADDI);
    is_ld   = (Opcode == OP_LD);
    is_st   = (Opcode == OP_ST);
    is_jump = (Opcode == OP_JUMP);
    is_beq  = (Opcode == OP_BEQ);
    is_blt  = (Opcode == OP_BLT);
    is_halt = (Opcode == OP_HALT);
    is_legal = is_reg || is_imm || is_ld || is_st || is_jump ||
               is_beq || is_blt || is_halt;

    alu_op = ALU_ADD;
    if ((Opcode == OP_AND) || (Opcode == OP_ANDI)) begin
      alu_op = ALU_AND;
    end else if (Opcode == OP_NAND) begin
      alu_op = ALU_NAND;
    end else if (Opcode == OP_NOR) begin
      alu_op = ALU_NOR;
    end
  end

  // State register and retired-instruction counter
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state   <= S_FETCH;
      Retired <= 16'd0;
    end else begin
      state <= next_state;
      if (retire) begin
        Retired <= Retired + 16'd1;
      end
    end
  end

  // Next state and control outputs
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcB    = 1'b0;
    MemToReg   = 1'b0;
    ALUControl = ALU_ADD;
    PCSource   = PC_INC;
    IllegalOp  = 1'b0;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          PCSource   = PC_INC;
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_halt) begin
          next_state = S_HALT;
        end else if (!is_legal) begin
          IllegalOp  = 1'b1;
          next_state = S_FETCH;
        end else if (is_jump) begin
          // A jump completes here, so it is the one DECODE exit that retires
          PCWrite    = 1'b1;
          PCSource   = PC_JUMP;
          next_state = S_FETCH;
          retire     = 1'b1;
        end else begin
          next_state = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_reg) begin
          ALUControl = alu_op;
          next_state = S_WB;
        end else if (is_imm) begin
          ALUControl = alu_op;
          ALUSrcB    = 1'b1;
          next_state = S_WB;
        end else if (is_ld || is_st) begin
          ALUControl = ALU_ADD;
          ALUSrcB    = 1'b1;
          next_state = S_MEM;
        end else if (is_beq || is_blt) begin
          if ((is_beq && Zero) || (is_blt && Negative)) begin
            PCWrite  = 1'b1;
            PCSource = PC_BRANCH;
          end
          next_state = S_FETCH;
          retire     = 1'b1;
        end else begin
          // Opcode changed under us: drop the instruction uncounted
          next_state = S_FETCH;
        end
      end

      S_MEM: begin
        if (is_ld) begin
          MemRead = 1'b1;
          if (MemReady) begin
            next_state = S_WB;
          end
        end else if (is_st) begin
          MemWrite = 1'b1;
          if (MemReady) begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
        end else begin
          next_state = S_FETCH;
        end
      end

      S_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = is_ld;
        next_state = S_FETCH;
        retire     = 1'b1;
      end

      S_HALT: begin
        next_state = S_HALT;
      end

      default: begin
        next_state = S_FETCH;
      end
    endcase

    // Clear wins over everything: no datapath side effects, no counting
    if (Clear) begin
      retire     = 1'b0;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcB    = 1'b0;
      MemToReg   = 1'b0;
      ALUControl = ALU_ADD;
      PCSource   = PC_INC;
      IllegalOp  = 1'b0;
      next_state = S_FETCH;
    end
  end

  assign Halted = (state == S_HALT);
  assign State  = state;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_controller
//
// Directed and randomized bench for multi_cycle_controller. Each instruction
// is expanded into the per-cycle trace its opcode calls for (state code,
// control vector, MemReady to drive) and the DUT is replayed against it.
// ---------------------------------------------------------------------------
module tb_multi_cycle_controller;

  logic        Clock;
  logic        Clear;
  logic [3:0]  Opcode;
  logic        Zero;
  logic        Negative;
  logic        MemReady;
  logic        PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcB, MemToReg;
  logic [1:0]  ALUControl;
  logic [1:0]  PCSource;
  logic        IllegalOp;
  logic        Halted;
  logic [2:0]  State;
  logic [15:0] Retired;

  multi_cycle_controller #(.OPW(4)) dut (
    .Clock(Clock), .Clear(Clear), .Opcode(Opcode), .Zero(Zero),
    .Negative(Negative), .MemReady(MemReady), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ALUSrcB(ALUSrcB), .MemToReg(MemToReg),
    .ALUControl(ALUControl), .PCSource(PCSource), .IllegalOp(IllegalOp),
    .Halted(Halted), .State(State), .Retired(Retired)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcB, MemToReg,
  //  ALUControl, PCSource, IllegalOp, Halted}
  logic [12:0] ctl_now;
  assign ctl_now = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcB,
                    MemToReg, ALUControl, PCSource, IllegalOp, Halted};

  typedef struct {
    logic [2:0]  st;
    logic [12:0] ctl;
    logic        mr;
  } cyc_t;

  cyc_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_ret = 16'd0;

  function automatic logic [12:0] mk(logic pcw, logic irw, logic mrd, logic mwr,
                                     logic rw, logic sb, logic m2r,
                                     logic [1:0] alu, logic [1:0] pcs,
                                     logic ill, logic hlt);
    return {pcw, irw, mrd, mwr, rw, sb, m2r, alu, pcs, ill, hlt};
  endfunction

  task automatic push(logic [2:0] st, logic [12:0] ctl, logic mr);
    cyc_t c;
    c.st = st; c.ctl = ctl; c.mr = mr;
    q.push_back(c);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expand one instruction into its expected cycle trace.
  // retires: instruction counts toward Retired; halts: ends in HALT.
  task automatic build(logic [3:0] op, logic z, logic n, int fw, int mw,
                       output logic retires, output logic halts);
    logic [1:0] alu;
    q.delete();
    retires = 1'b0;
    halts   = 1'b0;
    for (int i = 0; i < fw; i++) push(3'd0, mk(0,0,1,0,0,0,0,2'b00,2'b00,0,0), 1'b0);
    push(3'd0, mk(1,1,1,0,0,0,0,2'b00,2'b00,0,0), 1'b1);
    case (op)
      4'b0000, 4'b0100: alu = 2'b01;
      4'b0010:          alu = 2'b10;
      4'b0011:          alu = 2'b11;
      default:          alu = 2'b00;
    endcase
    case (op)
      4'b1111: begin
        push(3'd1, 13'd0, rnd_bit());
        halts = 1'b1;
      end
      4'b1000: begin
        push(3'd1, mk(1,0,0,0,0,0,0,2'b00,2'b10,0,0), rnd_bit());
        retires = 1'b1;
      end
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
        push(3'd1, 13'd0, rnd_bit());
        push(3'd2, mk(0,0,0,0,0,op[2],0,alu,2'b00,0,0), rnd_bit());
        push(3'd4, mk(0,0,0,0,1,0,0,2'b00,2'b00,0,0), rnd_bit());
        retires = 1'b1;
      end
      4'b0110, 4'b0111: begin
        push(3'd1, 13'd0, rnd_bit());
        push(3'd2, mk(0,0,0,0,0,1,0,2'b00,2'b00,0,0), rnd_bit());
        for (int i = 0; i <= mw; i++)
          push(3'd3, mk(0,0,!op[0],op[0],0,0,0,2'b00,2'b00,0,0), i == mw);
        if (!op[0]) push(3'd4, mk(0,0,0,0,1,0,1,2'b00,2'b00,0,0), rnd_bit());
        retires = 1'b1;
      end
      4'b1001, 4'b1010: begin
        logic take;
        take = op[1] ? n : z;
        push(3'd1, 13'd0, rnd_bit());
        push(3'd2, mk(take,0,0,0,0,0,0,2'b00,take ? 2'b01 : 2'b00,0,0), rnd_bit());
        retires = 1'b1;
      end
      default: begin
        push(3'd1, mk(0,0,0,0,0,0,0,2'b00,2'b00,1,0), rnd_bit());
      end
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic replay(int n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      MemReady = q[i].mr;
      #1;
      chk($sformatf("state[%0d]", i), 16'(State), 16'(q[i].st));
      chk($sformatf("ctl[%0d]", i), 16'(ctl_now), 16'(q[i].ctl));
      @(posedge Clock); #1;
    end
  endtask

  task automatic run_instr(logic [3:0] op, logic z, logic n, int fw, int mw);
    logic r, h;
    Opcode = op; Zero = z; Negative = n;
    build(op, z, n, fw, mw, r, h);
    replay(q.size());
    if (r) exp_ret = exp_ret + 16'd1;
    chk($sformatf("retired_op%h", op), Retired, exp_ret);
    chk($sformatf("end_state_op%h", op), 16'(State), h ? 16'd5 : 16'd0);
  endtask

  initial begin
    logic r, h;
    Clear = 1'b1; Opcode = 4'b0000; Zero = 1'b0; Negative = 1'b0; MemReady = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_state", 16'(State), 16'd0);
    chk("reset_retired", Retired, 16'd0);
    chk("reset_halted", 16'(Halted), 16'd0);
    // Clear forces controls off even though FETCH would fire with MemReady=1
    MemReady = 1'b1;
    #1;
    chk("clear_ctl_zero", 16'(ctl_now), 16'd0);
    @(posedge Clock); #1;
    chk("clear_hold_state", 16'(State), 16'd0);
    Clear = 1'b0;

    // ADD with no memory waits
    run_instr(4'b0001, 1'b0, 1'b0, 0, 0);
    // LD with three MEM wait cycles
    run_instr(4'b0110, 1'b0, 1'b0, 0, 3);
    // BEQ taken / not taken, BLT taken / not taken
    run_instr(4'b1001, 1'b1, 1'b0, 0, 0);
    run_instr(4'b1001, 1'b0, 1'b1, 0, 0);
    run_instr(4'b1010, 1'b0, 1'b1, 1, 0);
    run_instr(4'b1010, 1'b1, 1'b0, 0, 0);
    // Illegal opcode: IllegalOp pulse, nothing retired
    run_instr(4'b1100, 1'b0, 1'b0, 0, 0);
    // ST with fetch and memory waits, JUMP
    run_instr(4'b0111, 1'b0, 1'b0, 2, 2);
    run_instr(4'b1000, 1'b0, 1'b0, 0, 0);

    // Randomized mix (HALT excluded so the run keeps going)
    for (int k = 0; k < 60; k++) begin
      run_instr(4'($urandom_range(0, 14)), rnd_bit(), rnd_bit(),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Counter wrap: park Retired at 0xFFFF, then retire one JUMP
    force dut.Retired = 16'hFFFF;
    #1;
    release dut.Retired;
    exp_ret = 16'hFFFF;
    run_instr(4'b1000, 1'b0, 1'b0, 0, 0);
    chk("wrap_to_zero", Retired, 16'h0000);

    // Clear during a pending LD memory wait abandons the instruction
    run_instr(4'b0101, 1'b0, 1'b0, 0, 0);
    Opcode = 4'b0110;
    build(4'b0110, 1'b0, 1'b0, 0, 5, r, h);
    replay(5);
    chk("mid_mem_state", 16'(State), 16'd3);
    Clear = 1'b1; MemReady = 1'b1;
    #1;
    chk("mid_mem_clear_ctl", 16'(ctl_now), 16'd0);
    @(posedge Clock); #1;
    Clear = 1'b0;
    exp_ret = 16'd0;
    chk("mid_mem_abandon_state", 16'(State), 16'd0);
    chk("mid_mem_abandon_retired", Retired, exp_ret);

    // HALT: parked for 10 cycles regardless of MemReady, then Clear
    run_instr(4'b0011, 1'b0, 1'b0, 0, 0);
    run_instr(4'b1111, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      MemReady = k[0];
      #1;
      chk($sformatf("halt_state[%0d]", k), 16'(State), 16'd5);
      chk($sformatf("halt_ctl[%0d]", k), 16'(ctl_now), 16'(mk(0,0,0,0,0,0,0,2'b00,2'b00,0,1)));
      @(posedge Clock); #1;
    end
    chk("halt_retired_kept", Retired, exp_ret);
    Clear = 1'b1;
    @(posedge Clock); #1;
    Clear = 1'b0;
    chk("post_halt_state", 16'(State), 16'd0);
    chk("post_halt_halted", 16'(Halted), 16'd0);
    chk("post_halt_retired", Retired, 16'd0);
    exp_ret = 16'd0;

    // Machine runs normally after leaving HALT
    run_instr(4'b0100, 1'b0, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 The block SHALL have one parameter: OPW, default 4, opcode width (instruction bits [17:14]).
REQ-002 The block SHALL have port Clock, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port Clear, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port Opcode, input, OPW, opcode field of the instruction register.
REQ-005 The block SHALL have port Zero, input, 1, comparator equal flag (A == B) for the current operands.
REQ-006 The block SHALL have port Negative, input, 1, comparator less-than flag (A < B, signed 18-bit).
REQ-007 The block SHALL have port MemReady, input, 1, memory completion handshake, valid only while MemRead or MemWrite is high.
REQ-008 The block SHALL have the following control outputs: PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcB, MemToReg, each output, 1, datapath enables and selects.
REQ-009 The block SHALL have port ALUControl, output, 2, ALU operation: 00 ADD, 01 AND, 10 NAND, 11 NOR.
REQ-010 The block SHALL have port PCSource, output, 2, PC next-value select: 00 PC+1, 01 branch target, 10 jump target.
REQ-011 The block SHALL have the following status outputs: IllegalOp, output, 1, one-cycle pulse; Halted, output, 1; State, output, 3, current FSM state.
REQ-012 The block SHALL have port Retired, output, 16, count of completed instructions.

Function
REQ-013 Opcodes SHALL decode as follows: 0000 AND, 0001 ADD, 0010 NAND, 0011 NOR, 0100 ANDI, 0101 ADDI, 0110 LD, 0111 ST, 1000 JUMP, 1001 BEQ, 1010 BLT, 1111 HALT; all other opcodes are illegal.
REQ-014 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 are unreachable and go to FETCH.
REQ-015 Control outputs SHALL be combinational from the registered state and Opcode; every output not asserted by a state is 0.
REQ-016 FETCH SHALL assert MemRead; when MemReady=1 it asserts IRWrite, asserts PCWrite with PCSource=00, and moves to DECODE; when MemReady=0 it stays in FETCH.
REQ-017 DECODE SHALL take one cycle and branch on opcode: HALT goes to HALT; illegal pulses IllegalOp for that cycle and goes to FETCH; JUMP asserts PCWrite with PCSource=10 and goes to FETCH; all other opcodes go to EXEC.
REQ-018 EXEC, register ops: ALUControl per opcode, ALUSrcB=0, next state WB.
REQ-019 EXEC, immediate ops: ALUControl per opcode, ALUSrcB=1, next state WB.
REQ-020 EXEC, LD/ST: ALUControl=00, ALUSrcB=1 (address calculation), next state MEM.
REQ-021 EXEC, BEQ: assert PCWrite with PCSource=01 only if Zero=1; next state FETCH.
REQ-022 EXEC, BLT: assert PCWrite with PCSource=01 only if Negative=1; next state FETCH.
REQ-023 MEM SHALL assert MemRead for LD or MemWrite for ST and hold it until MemReady=1; then LD goes to WB and ST goes to FETCH.
REQ-024 WB SHALL assert RegWrite for one cycle, with MemToReg=1 for LD and 0 otherwise; next state FETCH.
REQ-025 Retired SHALL increment by 1 on each cycle that transitions into FETCH from DECODE (JUMP only), EXEC, MEM or WB; illegal opcodes are not counted; 0xFFFF wraps to 0x0000.
REQ-026 HALT SHALL hold Halted=1 and all control outputs at 0, and stay in HALT until Clear.
REQ-027 MemReady SHALL be ignored in every state other than FETCH and MEM.
REQ-028 Every instruction SHALL write at most one of PC, register file or memory per cycle; MemRead and MemWrite are never both high.

Reset
REQ-029 While Clear=1 at a rising edge, the next state SHALL be FETCH, Retired=0, Halted=0, and IllegalOp=0.
REQ-030 During any cycle in which Clear is high, all control outputs SHALL be forced to 0, regardless of state.
REQ-031 Clear asserted mid-instruction, including during a pending MemReady wait, SHALL abandon the instruction without counting it.
REQ-032 Clear SHALL take priority over MemReady and over all state transitions.

Verification
REQ-033 Release Clear, ADD (0001) with MemReady=1: state sequence 0,1,2,4,0; RegWrite high in exactly 1 cycle; ALUControl=00 in EXEC; Retired=1.
REQ-034 LD (0110) with MemReady held low 3 cycles in MEM: MemRead high for 4 MEM cycles; then WB with MemToReg=1; Retired increments once.
REQ-035 BEQ with Zero=1: PCWrite=1 and PCSource=01 in EXEC. BEQ with Zero=0: PCWrite=0 in EXEC. Both return to FETCH and count as retired.
REQ-036 Opcode 1100: IllegalOp pulses exactly 1 cycle in DECODE; next state FETCH; Retired unchanged.
REQ-037 HALT (1111): State=5 and Halted=1 persist for 10 cycles with MemReady toggling; Clear then gives State=0, Halted=0, Retired=0.
REQ-038 Preload Retired=0xFFFF with 65535 instructions, then retire one more: Retired=0x0000.
